switch_device_tx: RTL and testbench

// - Device-side transmitter feeding one ingress port of the multi-port switch; the other end of the switch's per-port tx-ready/Avalon-ST interface.
// - Buffers beats from a local source in a FIFO and starts a frame only while the switch asserts tx-ready.
// - Paces beats with a credit bucket so output never exceeds the configured port speed.

---
 rtl/switch_device_tx_if.sv | 14 +
 rtl/switch_device_tx.sv | 169 ++++++++++++++++
 tb/tb_switch_device_tx.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_device_tx_if.sv
// Beat stream between a source and a sink: valid/data/sop/eop forward, ready back.
// The transmitter uses one instance as its ingress port and one as its port towards the switch.
interface switch_device_tx_if #(
  parameter int DATA_W = 8
) ();
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              sop;
  logic              eop;
  logic              ready;

  modport master (output valid, data, sop, eop, input ready);
  modport slave  (input valid, data, sop, eop, output ready);
endinterface

// File: rtl/switch_device_tx.sv
// Device-side transmitter: FIFO-buffered frames, gated by switch tx-ready, paced by a credit bucket.
// Optional statistics counters are enabled with `define SWITCH_DEVICE_TX_STATS_EN.
module switch_device_tx #(
  parameter longint g_FREQUENCY  = 100_000_000,
  parameter int     g_DATA_WIDTH = 8,
  parameter int     g_FIFO_DEPTH = 16,
  parameter int     g_BURST      = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  longint             i_portSpeed,
  switch_device_tx_if.slave  i_src,
  switch_device_tx_if.master o_tx,
  output logic               o_busy
`ifdef SWITCH_DEVICE_TX_STATS_EN
  ,
  output logic [31:0]        o_frameCount,
  output logic [31:0]        o_dropCount
`endif
);
  localparam int          AW   = $clog2(g_FIFO_DEPTH);
  localparam int          BW   = g_DATA_WIDTH + 2;
  localparam logic [95:0] COST = 96'(g_FREQUENCY) * 96'(g_DATA_WIDTH);
  localparam logic [95:0] CAP  = COST * 96'(g_BURST);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DROP} state_t;

  // Accrue one cycle of port rate; negative or zero rates add nothing.
  function automatic logic [95:0] sat_add(input logic [95:0] acc, input longint rate);
    logic [95:0] sum;
    sum = acc + ((rate > 0) ? 96'(rate) : 96'd0);
    return (sum > CAP) ? CAP : sum;
  endfunction

  state_t                  r_state, w_stateNext;
  logic [BW-1:0]           r_mem [g_FIFO_DEPTH];
  logic [AW-1:0]           r_wrPtr, r_rdPtr;
  logic [AW:0]             r_count;
  logic [AW:0]             w_countNext;
  logic [95:0]             r_credit;
  logic                    r_ready;
  logic                    r_valid, r_sop, r_eop;
  logic [g_DATA_WIDTH-1:0] r_data;

  logic                    w_push, w_pop, w_send, w_empty, w_hasCredit;
  logic                    w_headSop, w_headEop;
  logic [g_DATA_WIDTH-1:0] w_headData;
  logic                    w_outSop, w_outEop;
  logic [g_DATA_WIDTH-1:0] w_outData;
  logic                    w_frameDone, w_dropBeat;

  assign w_push      = i_src.valid && r_ready;
  assign w_empty     = (r_count == '0);
  assign w_hasCredit = (r_credit >= COST);
  assign {w_headSop, w_headEop, w_headData} = r_mem[r_rdPtr];
  assign w_countNext = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    w_send      = 1'b0;
    w_outSop    = 1'b0;
    w_outEop    = 1'b0;
    w_outData   = '0;
    w_frameDone = 1'b0;
    w_dropBeat  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          if (!w_headSop) begin
            w_stateNext = S_DROP;
          end else if (o_tx.ready && w_hasCredit) begin
            w_pop     = 1'b1;
            w_send    = 1'b1;
            w_outSop  = 1'b1;
            w_outEop  = w_headEop;
            w_outData = w_headData;
            if (w_headEop) w_frameDone = 1'b1;
            else           w_stateNext = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (!w_empty && w_hasCredit) begin
          w_send = 1'b1;
          if (w_headSop) begin
            // New frame arrived before this one ended: close it with an empty eop beat.
            w_outEop    = 1'b1;
            w_frameDone = 1'b1;
            w_stateNext = S_IDLE;
          end else begin
            w_pop     = 1'b1;
            w_outEop  = w_headEop;
            w_outData = w_headData;
            if (w_headEop) begin
              w_frameDone = 1'b1;
              w_stateNext = S_IDLE;
            end
          end
        end
      end
      S_DROP: begin
        if (!w_empty) begin
          if (w_headSop) begin
            w_stateNext = S_IDLE;
          end else begin
            w_pop      = 1'b1;
            w_dropBeat = 1'b1;
          end
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
      r_credit <= '0;
      r_ready  <= 1'b0;
      r_valid  <= 1'b0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_data   <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_count  <= w_countNext;
      r_ready  <= (w_countNext != (AW+1)'(g_FIFO_DEPTH));
      r_credit <= sat_add(r_credit, i_portSpeed) - (w_send ? COST : 96'd0);
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      r_valid  <= w_send;
      r_sop    <= w_outSop;
      r_eop    <= w_outEop;
      r_data   <= w_outData;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wrPtr] <= {i_src.sop, i_src.eop, i_src.data};
  end

`ifdef SWITCH_DEVICE_TX_STATS_EN
  logic [31:0] r_frameCount, r_dropCount;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frameCount <= '0;
      r_dropCount  <= '0;
    end else begin
      if (w_frameDone) r_frameCount <= r_frameCount + 32'd1;
      if (w_dropBeat)  r_dropCount  <= r_dropCount + 32'd1;
    end
  end

  assign o_frameCount = r_frameCount;
  assign o_dropCount  = r_dropCount;
`endif

  assign i_src.ready = r_ready;
  assign o_tx.valid  = r_valid;
  assign o_tx.sop    = r_sop;
  assign o_tx.eop    = r_eop;
  assign o_tx.data   = r_data;
  assign o_busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_switch_device_tx.sv
// Randomised and directed bench for switch_device_tx against a queue-based frame/credit model.
module tb_switch_device_tx;
  localparam int          DW    = 8;
  localparam int          DEPTH = 16;
  localparam longint      FREQ  = 100_000_000;
  localparam logic [95:0] COST  = 96'd800_000_000;
  localparam logic [95:0] CAP   = 96'd3_200_000_000;

  typedef struct {
    int         c;
    logic       sop;
    logic       eop;
    logic [7:0] d;
  } ob_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint speed = 0;
  logic   busy;
`ifdef SWITCH_DEVICE_TX_STATS_EN
  logic [31:0] frame_cnt, drop_cnt;
`endif

  switch_device_tx_if #(.DATA_W(DW)) src_if ();
  switch_device_tx_if #(.DATA_W(DW)) tx_if ();

  switch_device_tx #(
    .g_FREQUENCY (FREQ),
    .g_DATA_WIDTH(DW),
    .g_FIFO_DEPTH(DEPTH),
    .g_BURST     (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_portSpeed(speed),
    .i_src      (src_if),
    .o_tx       (tx_if),
    .o_busy     (busy)
`ifdef SWITCH_DEVICE_TX_STATS_EN
    ,
    .o_frameCount(frame_cnt),
    .o_dropCount (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         src_rate = 100;
  int         accepted = 0;
  logic       force_valid = 1'b0;
  logic [9:0] srcq[$];
  ob_t        outlog[$];

  // Reference model: frame rules applied to a beat queue and a plain credit number.
  logic [9:0]  mq[$];
  logic [95:0] m_credit;
  int          m_mode;
  int unsigned m_frames, m_drops;
  logic        e_valid, e_sop, e_eop, e_ready, e_busy;
  logic [7:0]  e_data;

  always @(posedge clk) begin : model
    logic [9:0]  h;
    logic [9:0]  beat_out;
    logic        sent, take, nonempty;
    logic [95:0] gain;
    if (rst) begin
      mq.delete();
      m_credit = '0;
      m_mode   = 0;
      m_frames = 0;
      m_drops  = 0;
      e_valid = 0; e_sop = 0; e_eop = 0; e_data = 0; e_ready = 0; e_busy = 0;
    end else begin
      sent = 0; take = 0; beat_out = '0; h = '0;
      nonempty = (mq.size() > 0);
      if (nonempty) h = mq[0];
      case (m_mode)
        0: if (nonempty) begin
             if (!h[9]) m_mode = 2;
             else if (tx_if.ready && m_credit >= COST) begin
               sent = 1; take = 1; beat_out = h;
               if (h[8]) m_frames++;
               else      m_mode = 1;
             end
           end
        1: if (nonempty && m_credit >= COST) begin
             sent = 1;
             if (h[9]) begin
               beat_out = 10'b01_0000_0000;
               m_frames++;
               m_mode = 0;
             end else begin
               take = 1; beat_out = h;
               if (h[8]) begin m_frames++; m_mode = 0; end
             end
           end
        default: if (nonempty) begin
             if (h[9]) m_mode = 0;
             else begin take = 1; m_drops++; end
           end
      endcase
      gain = (speed > 0) ? 96'(speed) : 96'd0;
      m_credit = (m_credit + gain > CAP) ? CAP : m_credit + gain;
      if (sent) m_credit = m_credit - COST;
      if (take) void'(mq.pop_front());
      if (src_if.valid && e_ready) mq.push_back({src_if.sop, src_if.eop, src_if.data});
      e_ready = (mq.size() < DEPTH);
      e_valid = sent;
      e_sop   = beat_out[9];
      e_eop   = beat_out[8];
      e_data  = beat_out[7:0];
      e_busy  = (m_mode != 0);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // One clock: compare against the model, log output beats, then drive the next source beat.
  task automatic step();
    @(negedge clk);
    cyc++;
    chk("valid", tx_if.valid, e_valid);
    chk("ready", src_if.ready, e_ready);
    chk("busy", busy, e_busy);
    if (e_valid) begin
      chk("data", tx_if.data, e_data);
      chk("sop", tx_if.sop, e_sop);
      chk("eop", tx_if.eop, e_eop);
    end
`ifdef SWITCH_DEVICE_TX_STATS_EN
    chk("frameCount", frame_cnt, m_frames);
    chk("dropCount", drop_cnt, m_drops);
`endif
    if (tx_if.valid === 1'b1) outlog.push_back('{cyc, tx_if.sop, tx_if.eop, tx_if.data});
    if (force_valid) begin
      src_if.valid = 1'b1;
      {src_if.sop, src_if.eop, src_if.data} = 10'($urandom);
    end else if (srcq.size() > 0 && $urandom_range(99) < src_rate) begin
      src_if.valid = 1'b1;
      {src_if.sop, src_if.eop, src_if.data} = srcq[0];
    end else begin
      src_if.valid = 1'b0;
      {src_if.sop, src_if.eop, src_if.data} = 10'($urandom);
    end
    if (src_if.valid && src_if.ready && !force_valid) begin
      void'(srcq.pop_front());
      accepted++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    srcq.delete();
    outlog.delete();
    accepted = 0;
  endtask

  task automatic add_frame(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++)
      srcq.push_back({(i == 0), (i == n - 1), 8'(base + 8'(i))});
  endtask

  task automatic gen_frame();
    int len, kind;
    len  = $urandom_range(1, 8);
    kind = $urandom_range(9);
    for (int i = 0; i < len; i++)
      srcq.push_back({(i == 0) && (kind != 0), (i == len - 1) && (kind != 1), 8'($urandom)});
  endtask

  function automatic int spacing_errs(input int from, input int to, input int gap);
    int n = 0;
    for (int i = from + 1; i <= to; i++)
      if (outlog[i].c - outlog[i-1].c != gap) n++;
    return n;
  endfunction

  initial begin
    src_if.valid = 1'b0;
    src_if.sop   = 1'b0;
    src_if.eop   = 1'b0;
    src_if.data  = '0;
    tx_if.ready  = 1'b1;

    // Reset held with i_valid high: nothing written, nothing sent.
    speed = 800_000_000;
    force_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_valid", tx_if.valid, 0);
      chk("rst_busy", busy, 0);
    end
    rst = 1'b0;
    force_valid = 1'b0;
    step();
    chk("ready_after_rst", src_if.ready, 1);
    repeat (10) step();
    chk("no_write_in_rst", outlog.size(), 0);

    // Pacing at half line rate.
    speed = 400_000_000;
    do_reset();
    add_frame(10, 8'h10);
    repeat (40) step();
    chk("pace_count", outlog.size(), 10);
    if (outlog.size() == 10) begin
      chk("pace_sop", outlog[0].sop, 1);
      chk("pace_eop", outlog[9].eop, 1);
      chk("pace_last_data", outlog[9].d, 8'h19);
      chk("pace_gap2", spacing_errs(0, 9, 2), 0);
    end

    // Line rate with full credit bucket.
    speed = 800_000_000;
    tx_if.ready = 1'b0;
    do_reset();
    add_frame(10, 8'h20);
    repeat (30) step();
    chk("line_gated", outlog.size(), 0);
    tx_if.ready = 1'b1;
    repeat (20) step();
    chk("line_count", outlog.size(), 10);
    if (outlog.size() == 10) chk("line_b2b", spacing_errs(0, 9, 1), 0);

    // Zero speed: nothing leaves, FIFO fills to 16.
    speed = 0;
    do_reset();
    add_frame(10, 8'h30);
    add_frame(10, 8'h30);
    repeat (100) step();
    chk("zero_no_out", outlog.size(), 0);
    chk("zero_accepted", accepted, 16);
    chk("zero_full_ready", src_if.ready, 0);
    speed = 800_000_000;
    repeat (40) step();
    chk("zero_drain", outlog.size(), 20);

    // Gate closed for 50 cycles, then a burst followed by pacing.
    speed = 400_000_000;
    tx_if.ready = 1'b0;
    do_reset();
    add_frame(10, 8'h40);
    repeat (50) step();
    chk("gate_no_out", outlog.size(), 0);
    tx_if.ready = 1'b1;
    repeat (30) step();
    chk("gate_count", outlog.size(), 10);
    if (outlog.size() == 10) begin
      chk("gate_burst4", spacing_errs(0, 3, 1), 0);
      chk("gate_paced_tail", outlog[9].c - outlog[8].c, 2);
    end

    // Dropping tx-ready mid-frame does not abort it; next frame waits.
    speed = 800_000_000;
    do_reset();
    add_frame(10, 8'h50);
    add_frame(3, 8'h60);
    for (int i = 0; i < 100 && outlog.size() < 3; i++) step();
    chk("mid_reached3", outlog.size() >= 3, 1);
    tx_if.ready = 1'b0;
    repeat (30) step();
    chk("mid_count", outlog.size(), 10);
    if (outlog.size() == 10) begin
      chk("mid_eop", outlog[9].eop, 1);
      chk("mid_data", outlog[9].d, 8'h59);
    end
    tx_if.ready = 1'b1;
    repeat (20) step();
    chk("mid_next", outlog.size(), 13);
    if (outlog.size() == 13) chk("mid_next_sop", {outlog[10].sop, outlog[10].d}, {1'b1, 8'h60});

    // Stray mid-frame beats are discarded before a good frame.
    do_reset();
    srcq.push_back({2'b00, 8'hAA});
    srcq.push_back({2'b00, 8'hAB});
    add_frame(4, 8'h70);
    repeat (30) step();
    chk("mal_count", outlog.size(), 4);
    if (outlog.size() == 4) begin
      chk("mal_first", {outlog[0].sop, outlog[0].d}, {1'b1, 8'h70});
      chk("mal_last", {outlog[3].eop, outlog[3].d}, {1'b1, 8'h73});
    end
`ifdef SWITCH_DEVICE_TX_STATS_EN
    chk("mal_drops", drop_cnt, 2);
    chk("mal_frames", frame_cnt, 1);
`endif

    // Frame without eop is closed by an empty eop beat when the next sop arrives.
    do_reset();
    srcq.push_back({2'b10, 8'h80});
    srcq.push_back({2'b00, 8'h81});
    srcq.push_back({2'b00, 8'h82});
    add_frame(2, 8'h90);
    repeat (30) step();
    chk("trunc_count", outlog.size(), 6);
    if (outlog.size() == 6) begin
      chk("trunc_close", {outlog[3].sop, outlog[3].eop, outlog[3].d}, {2'b01, 8'h00});
      chk("trunc_next", {outlog[4].sop, outlog[4].d}, {1'b1, 8'h90});
    end

    // Random traffic, speeds, gating and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) begin
        case ($urandom_range(5))
          0: speed = 0;
          1: speed = 200_000_000;
          2: speed = 400_000_000;
          3: speed = 800_000_000;
          4: speed = 1_600_000_000;
          default: speed = -5;
        endcase
      end
      if ($urandom_range(9) == 0) tx_if.ready = ~tx_if.ready;
      if ($urandom_range(99) == 0) src_rate = $urandom_range(20, 100);
      if (srcq.size() < 4) gen_frame();
      if (i == 1500) rst = 1'b1;
      if (i == 1502) rst = 1'b0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
